// File: rtl/test_monitor_pkg.sv
// ============================================================================
// Module      : test_monitor_pkg
// Description : Shared state encoding and default mailbox/console addresses
//               for the test monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package test_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } mon_state_e;

    localparam logic [31:0] C_TOHOST_ADDR_DEF  = 32'h0000_1000;
    localparam logic [31:0] C_CONSOLE_ADDR_DEF = 32'h0000_1004;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered occupancy, sticky overflow
//               and a zeroed head while empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             overflow
);

    localparam int              c_addr_w = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_depth = (c_addr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    logic                r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);
    assign w_pop   = pop && !w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push  = push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (push && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign valid    = !w_empty;
    assign data     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/test_monitor.sv
// ============================================================================
// Module      : test_monitor
// Description : Watches CPU stores for a tohost pass/fail mailbox and a
//               console byte sink; optional RUN timeout under
//               TEST_MONITOR_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module test_monitor
    import test_monitor_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = C_TOHOST_ADDR_DEF,
    parameter logic [31:0] CONSOLE_ADDR   = C_CONSOLE_ADDR_DEF,
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code,
    output logic        timeout,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        con_overflow
);

    mon_state_e  r_state;
    mon_state_e  w_state_nxt;
    logic [30:0] r_fail_code;
    logic [30:0] w_fail_code_nxt;
    logic        r_done;
    logic        r_pass;
    logic        r_timeout;

    logic w_tohost_wr;
    logic w_console_wr;
    logic w_timeout_hit;

    // Even tohost values are not decisions and are ignored outright.
    assign w_tohost_wr  = wr && (addr == TOHOST_ADDR) && wdata[0];
    assign w_console_wr = wr && (addr == CONSOLE_ADDR);

`ifdef TEST_MONITOR_TIMEOUT_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles <= '0;
        end else if (r_state == ST_RUN) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign w_timeout_hit = (r_state == ST_RUN) && (r_cycles == TIMEOUT_CYCLES - 32'd1);
`else
    wire w_unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign w_timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_fail_code_nxt = r_fail_code;
        unique case (r_state)
            ST_RUN: begin
                // A tohost decision outranks a coincident timeout.
                if (w_tohost_wr) begin
                    if (wdata == 32'd1) begin
                        w_state_nxt = ST_PASS;
                    end else begin
                        w_state_nxt     = ST_FAIL;
                        w_fail_code_nxt = wdata[31:1];
                    end
                end else if (w_timeout_hit) begin
                    w_state_nxt = ST_TIMEOUT;
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_fail_code <= '0;
        end else begin
            r_done      <= (w_state_nxt != ST_RUN);
            r_pass      <= (w_state_nxt == ST_PASS);
            r_timeout   <= (w_state_nxt == ST_TIMEOUT);
            r_fail_code <= w_fail_code_nxt;
        end
    end

    assign done      = r_done;
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign fail_code = r_fail_code;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_console_wr),
        .push_data (wdata[7:0]),
        .pop       (con_ready),
        .valid     (con_valid),
        .data      (con_data),
        .overflow  (con_overflow)
    );

endmodule

`default_nettype wire

// File: tb/tb_test_monitor.sv
// ============================================================================
// Module      : tb_test_monitor
// Description : Directed and randomized checks of test_monitor against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_test_monitor;

    localparam logic [31:0] c_tohost  = 32'h0000_1000;
    localparam logic [31:0] c_console = 32'h0000_1004;
    localparam int          c_depth   = 8;
    localparam int          c_to      = 20;
`ifdef TEST_MONITOR_TIMEOUT_EN
    localparam bit          c_to_en   = 1'b1;
`else
    localparam bit          c_to_en   = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        done;
    logic        pass;
    logic [30:0] fail_code;
    logic        timeout;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;
    logic        con_overflow;

    int n_cmp;
    int n_err;

    // Reference model: outcome name, cycle count and a byte queue.
    int          m_outcome;   // 0 running, 1 pass, 2 fail, 3 timeout
    logic [30:0] m_code;
    int          m_cycles;
    logic [7:0]  m_q[$];
    bit          m_ovf;

    test_monitor #(
        .TOHOST_ADDR    (c_tohost),
        .CONSOLE_ADDR   (c_console),
        .FIFO_DEPTH     (c_depth),
        .TIMEOUT_CYCLES (32'(c_to))
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr         (addr),
        .wdata        (wdata),
        .wr           (wr),
        .done         (done),
        .pass         (pass),
        .fail_code    (fail_code),
        .timeout      (timeout),
        .con_valid    (con_valid),
        .con_data     (con_data),
        .con_ready    (con_ready),
        .con_overflow (con_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_outcome = 0;
        m_code    = '0;
        m_cycles  = 0;
        m_q.delete();
        m_ovf     = 1'b0;
    endfunction

    function automatic void model_edge(input logic w, input logic [31:0] a,
                                       input logic [31:0] d, input logic rdy);
        bit popped;
        if (m_outcome == 0) begin
            if (w && a == c_tohost && d[0]) begin
                if (d == 32'd1) begin
                    m_outcome = 1;
                end else begin
                    m_outcome = 2;
                    m_code    = d[31:1];
                end
            end else if (c_to_en && m_cycles == c_to - 1) begin
                m_outcome = 3;
            end
            m_cycles++;
        end
        popped = (m_q.size() > 0) && rdy;
        if (popped) void'(m_q.pop_front());
        if (w && a == c_console) begin
            if (m_q.size() == c_depth) m_ovf = 1'b1;
            else m_q.push_back(d[7:0]);
        end
    endfunction

    task automatic compare_all();
        chk("done", {31'd0, done}, {31'd0, m_outcome != 0});
        chk("pass", {31'd0, pass}, {31'd0, m_outcome == 1});
        chk("fail_code", {1'b0, fail_code}, (m_outcome == 2) ? {1'b0, m_code} : 32'd0);
        chk("timeout", {31'd0, timeout}, {31'd0, m_outcome == 3});
        chk("con_valid", {31'd0, con_valid}, {31'd0, m_q.size() > 0});
        chk("con_data", {24'd0, con_data}, (m_q.size() > 0) ? {24'd0, m_q[0]} : 32'd0);
        chk("con_overflow", {31'd0, con_overflow}, {31'd0, m_ovf});
    endtask

    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy);
        wr        = w;
        addr      = a;
        wdata     = d;
        con_ready = rdy;
        @(posedge clk);
        model_edge(w, a, d, rdy);
        @(negedge clk);
        compare_all();
        wr        = 1'b0;
        con_ready = 1'b0;
    endtask

    task automatic do_reset();
        wr        = 1'b0;
        con_ready = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        addr  = '0;
        wdata = '0;
        wr    = 1'b0;
        con_ready = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // Pass, then a later fail store is ignored.
        step(1'b1, c_tohost, 32'h1, 1'b0);
        chk("pass_done", {31'd0, done}, 32'd1);
        chk("pass_pass", {31'd0, pass}, 32'd1);
        step(1'b1, c_tohost, 32'h7, 1'b0);
        chk("pass_hold", {31'd0, pass}, 32'd1);
        chk("pass_code", {1'b0, fail_code}, 32'd0);

        // Fail with code 3; even write beforehand is ignored.
        do_reset();
        step(1'b1, c_tohost, 32'h6, 1'b0);
        chk("even_ignored", {31'd0, done}, 32'd0);
        step(1'b1, c_tohost, 32'h7, 1'b0);
        chk("fail_code3", {1'b0, fail_code}, 32'd3);
        chk("fail_done", {31'd0, done}, 32'd1);
        chk("fail_nopass", {31'd0, pass}, 32'd0);

        // Timeout at the boundary, and tohost winning on the last cycle.
        do_reset();
        for (int i = 0; i < c_to - 1; i++) step(1'b0, 32'h0, 32'h0, 1'b0);
        chk("to_not_yet", {31'd0, timeout}, 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b0);
        chk("to_fired", {31'd0, timeout}, {31'd0, c_to_en});
        do_reset();
        for (int i = 0; i < c_to - 1; i++) step(1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b1, c_tohost, 32'h1, 1'b0);
        chk("to_tie_pass", {31'd0, pass}, 32'd1);
        chk("to_tie_noto", {31'd0, timeout}, 32'd0);

        // Console overflow and in-order drain.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, c_console, 32'h41 + 32'(i), 1'b0);
        chk("ovf_set", {31'd0, con_overflow}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain", {24'd0, con_data}, 32'h41 + 32'(i));
            step(1'b0, 32'h0, 32'h0, 1'b1);
        end
        chk("ovf_empty", {31'd0, con_valid}, 32'd0);

        // Push and pop together while full.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, c_console, 32'h10 + 32'(i), 1'b0);
        step(1'b1, c_console, 32'h5A, 1'b1);
        chk("pp_no_ovf", {31'd0, con_overflow}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("pp_drain", {24'd0, con_data}, (i == 7) ? 32'h5A : 32'h11 + 32'(i));
            step(1'b0, 32'h0, 32'h0, 1'b1);
        end

        // Asynchronous reset mid-test.
        do_reset();
        step(1'b1, c_tohost, 32'h7, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, c_console, 32'h30 + 32'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, con_valid}, 32'd0);
        chk("rst_ovf", {31'd0, con_overflow}, 32'd0);
        @(negedge clk);
        do_reset();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            int unsigned sel;
            logic [31:0] a;
            logic [31:0] d;
            if ($urandom_range(0, 59) == 0) do_reset();
            sel = $urandom_range(0, 15);
            if (sel == 0) begin
                a = c_tohost;
                case ($urandom_range(0, 3))
                    0: d = 32'h1;
                    1: d = $urandom | 32'h1;
                    default: d = $urandom & 32'hFFFF_FFFE;
                endcase
            end else if (sel < 10) begin
                a = c_console;
                d = $urandom;
            end else begin
                a = 32'h0000_2000 | ($urandom & 32'h0000_0FFC);
                d = $urandom;
            end
            step(1'($urandom_range(0, 1)), a, d, ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameter TOHOST_ADDR, default 32'h0000_1000, meaning the word address of the pass/fail mailbox.
REQ-002 SHALL have parameter CONSOLE_ADDR, default 32'h0000_1004, meaning the word address of the console byte sink.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning the console FIFO entries; power of two, 2..64.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 32'd10000, meaning the RUN cycles before timeout.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port addr, input, 32 bits: the CPU data-bus address.
REQ-008 SHALL have port wdata, input, 32 bits: the CPU store data.
REQ-009 SHALL have port wr, input, 1 bit: the store strobe, one store per high cycle.
REQ-010 SHALL have port done, output, 1 bit: the test finished (PASS, FAIL or TIMEOUT).
REQ-011 SHALL have port pass, output, 1 bit: the test finished in PASS.
REQ-012 SHALL have port fail_code, output, 31 bits: the FAIL code, 0 unless in FAIL.
REQ-013 SHALL have port timeout, output, 1 bit: the test finished in TIMEOUT.
REQ-014 SHALL have port con_valid, output, 1 bit: the console FIFO is non-empty.
REQ-015 SHALL have port con_data, output, 8 bits: the FIFO head byte, valid when con_valid.
REQ-016 SHALL have port con_ready, input, 1 bit: the consumer pops the head when high with con_valid.
REQ-017 SHALL have port con_overflow, output, 1 bit: sticky flag, a console byte was dropped.

Function
REQ-018 SHALL implement state machine RUN, PASS, FAIL, TIMEOUT; PASS, FAIL and TIMEOUT are terminal until reset.
REQ-019 SHALL, in RUN, on wr && addr==TOHOST_ADDR && wdata==1, enter PASS next cycle.
REQ-020 SHALL, in RUN, on wr && addr==TOHOST_ADDR && wdata[0]==1 && wdata!=1, enter FAIL and latch fail_code=wdata[31:1].
REQ-021 SHALL ignore tohost writes with wdata[0]==0, and all tohost writes in terminal states.
REQ-022 SHALL register done/pass/fail_code/timeout from state: asserted the cycle after the deciding event, held while terminal.
REQ-023 SHALL count cycles spent in RUN; when the count reaches TIMEOUT_CYCLES-1 with no tohost decision that cycle, enter TIMEOUT next cycle.
REQ-024 SHALL give a tohost decision priority over timeout when both occur in the same cycle.
REQ-025 SHALL push wdata[7:0] into the console FIFO on wr && addr==CONSOLE_ADDR, in any state.
REQ-026 SHALL pop the FIFO on con_valid && con_ready; con_data advances next cycle.
REQ-027 SHALL, on push into an empty FIFO, raise con_valid the next cycle (1-cycle latency, no bypass).
REQ-028 SHALL, on push while full without pop, drop the byte and set con_overflow until reset.
REQ-029 SHALL, on push and pop in the same cycle while full, accept both with occupancy unchanged and no overflow.
REQ-030 SHALL wrap the FIFO pointers modulo FIFO_DEPTH and keep an occupancy count of log2(FIFO_DEPTH)+1 bits.
REQ-031 SHALL treat addresses other than TOHOST_ADDR and CONSOLE_ADDR as no-ops.

Reset
REQ-032 SHALL, on rst_n low at any time (including mid-test), asynchronously set the state to RUN, timeout counter 0, FIFO empty, con_overflow 0, and done/pass/timeout/con_valid to 0, fail_code to 0 and con_data to 0.
REQ-033 SHALL act on no stores during reset; operation resumes at the first rising clk edge after rst_n goes high.

Configuration
REQ-034 SHALL support macro TEST_MONITOR_TIMEOUT_EN.
  - Defined: the timeout counter and TIMEOUT state are compiled in.
  - Undefined: the counter is absent, TIMEOUT is unreachable and timeout is tied 0.

Structure
REQ-035 SHALL take from package test_monitor_pkg the state enum (mon_state_e) and the default TOHOST/CONSOLE address constants.
REQ-036 SHALL instantiate the console FIFO as sub-module sync_fifo, parameterised by width 8 and FIFO_DEPTH.

Verification
REQ-037 SHALL include a pass test: store 32'h1 to 0x1000 -> pass=1, done=1 one cycle later; a later store of 32'h7 does not alter the outputs.
REQ-038 SHALL include a fail test: store 32'h0000_0007 to 0x1000 -> fail_code=3, done=1, pass=0.
REQ-039 SHALL include a timeout test (with TEST_MONITOR_TIMEOUT_EN, TIMEOUT_CYCLES=20): no stores -> timeout=1 after 20 cycles; a tohost 32'h1 store on cycle 19 yields pass instead.
REQ-040 SHALL include a console overflow test (FIFO_DEPTH=8, con_ready=0): push 9 bytes 0x41..0x49 -> con_overflow=1; the drain yields 0x41..0x48 in order.
REQ-041 SHALL include a full-FIFO push/pop test: simultaneous push 0x5A and pop when full -> no overflow, and 0x5A is drained last.
REQ-042 SHALL include a reset test: rst_n pulsed low while in FAIL with 3 bytes queued -> done=0, con_valid=0, con_overflow=0 immediately.
